// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the writeback unit
// Contents: XLEN_C/AW_C widths, wb_entry_t queue entry, wb_state_t FSM states.
package wb_pkg;

  localparam int XLEN_C = 32;
  localparam int AW_C   = 5;

  typedef struct packed {
    logic [AW_C-1:0]   rd;
    logic [XLEN_C-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_INIT,
    WB_RUN
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous write queue of wb_entry_t
// Ports:
//   clk, reset           clock, synchronous active-high reset (flushes queue)
//   push, push_entry     enqueue request and entry (ignored when full)
//   pop                  dequeue head (ignored when empty)
//   full, empty, count   occupancy status; count is clog2(DEPTH)+1 bits
//   entries, valid, head storage array, per-slot valid mask and head pointer
//                        exposed for the bypass search
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  wb_entry_t                 push_entry,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count,
  output wb_entry_t [DEPTH-1:0]     entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH)-1:0]  head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]          wr_ptr;
  wb_entry_t [DEPTH-1:0]  mem;
  logic                   do_push;
  logic                   do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign entries = mem;

  // Storage is not reset: the valid mask alone qualifies entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      head   <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr]   <= push_entry;
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - arbitrates ALU/load results into an in-order register file write stream
// Optional feature macro: WB_BYPASS_EN (builds the pending-write bypass search).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   alu_valid/alu_ready/alu_rd/alu_data ALU result handshake (priority source)
//   ld_valid/ld_ready/ld_rd/ld_data     load result handshake
//   rf_we/rf_waddr/rf_wdata             registered register file write port
//   q_addr1/q_addr2                     bypass query addresses
//   q_hit1/q_hit2, q_data1/q_data2      newest pending write for each query
//   busy                                queue non-empty or a write in flight
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  input  logic [AW-1:0]   q_addr1,
  input  logic [AW-1:0]   q_addr2,
  output logic            q_hit1,
  output logic            q_hit2,
  output logic [XLEN-1:0] q_data1,
  output logic [XLEN-1:0] q_data2,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);

  wb_state_t              state;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [PW:0]            fifo_count;
  wb_entry_t [DEPTH-1:0]  fifo_entries;
  logic [DEPTH-1:0]       fifo_valid;
  logic [PW-1:0]          fifo_head;
  wb_entry_t              head_entry;
  wb_entry_t              push_entry;
  logic                   alu_xfer;
  logic                   ld_xfer;
  logic                   push;
  logic                   pop;

  // Readiness uses the pre-pop occupancy so ready never depends on this
  // cycle's commit. Gating with reset keeps readys low while reset is held.
  assign alu_ready = !reset && (state == WB_RUN) && !fifo_full;
  assign ld_ready  = !reset && (state == WB_RUN) && !fifo_full && !alu_valid;

  assign alu_xfer = alu_valid && alu_ready;
  assign ld_xfer  = ld_valid && ld_ready;

  // Writes to x0 complete the handshake but are dropped here.
  assign push       = (alu_xfer && (alu_rd != '0)) || (ld_xfer && (ld_rd != '0));
  assign push_entry = alu_xfer ? '{rd: alu_rd, data: alu_data}
                               : '{rd: ld_rd,  data: ld_data};

  assign pop        = (state == WB_RUN) && !fifo_empty;
  assign head_entry = fifo_entries[fifo_head];
  assign busy       = (fifo_count != '0) || rf_we;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count),
    .entries    (fifo_entries),
    .valid      (fifo_valid),
    .head       (fifo_head)
  );

  // INIT lasts exactly one cycle so the first post-reset edge, which the
  // register file ignores, never carries a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WB_INIT;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state)
        WB_INIT: begin
          state <= WB_RUN;
          rf_we <= 1'b0;
        end
        WB_RUN: begin
          rf_we <= !fifo_empty;
          if (!fifo_empty) begin
            rf_waddr <= head_entry.rd;
            rf_wdata <= head_entry.data;
          end
        end
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  logic [1:0][AW-1:0]   qa;
  logic [1:0]           qh;
  logic [1:0][XLEN-1:0] qd;

  assign qa = {q_addr2, q_addr1};

  // Scan from oldest to newest so a later match overrides an earlier one;
  // the in-flight rf_* write is older than anything still queued.
  always_comb begin
    qh = '0;
    qd = '0;
    for (int p = 0; p < 2; p++) begin
      if (rf_we && (rf_waddr == qa[p])) begin
        qh[p] = 1'b1;
        qd[p] = rf_wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_valid[fifo_head + PW'(i)] &&
            (fifo_entries[fifo_head + PW'(i)].rd == qa[p])) begin
          qh[p] = 1'b1;
          qd[p] = fifo_entries[fifo_head + PW'(i)].data;
        end
      end
      if (qa[p] == '0) begin
        qh[p] = 1'b0;
        qd[p] = '0;
      end
    end
  end

  assign q_hit1  = qh[0];
  assign q_hit2  = qh[1];
  assign q_data1 = qd[0];
  assign q_data2 = qd[1];
`else
  logic unused_bypass;
  assign unused_bypass = ^{q_addr1, q_addr2, fifo_valid};

  assign q_hit1  = 1'b0;
  assign q_hit2  = 1'b0;
  assign q_data1 = '0;
  assign q_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - self-checking bench for writeback_unit against a queue-based model
module tb_writeback_unit;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
`ifdef WB_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid, ld_ready;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [AW-1:0]   q_addr1, q_addr2;
  logic            q_hit1, q_hit2;
  logic [XLEN-1:0] q_data1, q_data2;
  logic            busy;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_data1(q_data1), .q_data2(q_data2),
    .busy(busy)
  );

  // Register file attached to the write port.
  logic [XLEN-1:0] rf_mem [32];
  bit              rf_written [32];
  always @(posedge clk) begin
    if (rf_we) begin
      rf_mem[rf_waddr]     <= rf_wdata;
      rf_written[rf_waddr] <= 1'b1;
    end
  end

  // Reference model: pending writes in accept order plus the write on the port.
  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t pend [$];
  wr_t m_cur   = '0;
  bit  m_we    = 1'b0;
  bit  m_init  = 1'b1;
  bit  started = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void bypass(input logic [AW-1:0] a, output logic h, output logic [XLEN-1:0] d);
    h = 1'b0;
    d = '0;
    if (BP && a != '0) begin
      if (m_we && m_cur.rd == a) begin
        h = 1'b1;
        d = m_cur.data;
      end
      foreach (pend[i]) begin
        if (pend[i].rd == a) begin
          h = 1'b1;
          d = pend[i].data;
        end
      end
    end
  endfunction

  // One clock: check outputs, advance the model across the edge.
  task automatic cycle(output bit a_acc, output bit l_acc);
    logic            exp_ar, exp_lr, eh;
    logic [XLEN-1:0] ed;
    #1;
    exp_ar = !reset && !m_init && (pend.size() < DEPTH);
    exp_lr = exp_ar && !alu_valid;
    if (started) begin
      chk("alu_ready", 32'(alu_ready), 32'(exp_ar));
      chk("ld_ready",  32'(ld_ready),  32'(exp_lr));
      chk("rf_we",     32'(rf_we),     32'(m_we));
      chk("rf_waddr",  32'(rf_waddr),  32'(m_cur.rd));
      chk("rf_wdata",  rf_wdata,       m_cur.data);
      chk("busy",      32'(busy),      32'((pend.size() != 0) || m_we));
      bypass(q_addr1, eh, ed);
      chk("q_hit1",  32'(q_hit1), 32'(eh));
      chk("q_data1", q_data1,     ed);
      bypass(q_addr2, eh, ed);
      chk("q_hit2",  32'(q_hit2), 32'(eh));
      chk("q_data2", q_data2,     ed);
    end
    a_acc = alu_valid && exp_ar;
    l_acc = ld_valid && exp_lr;
    @(posedge clk);
    if (reset) begin
      pend.delete();
      m_init = 1'b1;
      m_we   = 1'b0;
      m_cur  = '0;
    end else if (m_init) begin
      m_init = 1'b0;
      m_we   = 1'b0;
    end else begin
      if (pend.size() != 0) begin
        m_cur = pend.pop_front();
        m_we  = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (a_acc && alu_rd != '0)
        pend.push_back('{rd: alu_rd, data: alu_data});
      else if (l_acc && ld_rd != '0)
        pend.push_back('{rd: ld_rd, data: ld_data});
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain();
    bit a, l;
    int n;
    n = 0;
    while ((pend.size() != 0 || m_we) && n < 3 * DEPTH) begin
      cycle(a, l);
      n++;
    end
    cycle(a, l);
    if (pend.size() != 0 || m_we) begin
      checks++;
      failures++;
      $error("FAIL drain_timeout observed=busy expected=idle");
    end
  endtask

  task automatic hold_alu(input logic [AW-1:0] rd, input logic [XLEN-1:0] data);
    bit a, l;
    int n;
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_data  = data;
    a = 1'b0;
    n = 0;
    while (!a && n < 8) begin
      cycle(a, l);
      n++;
    end
    chk("alu_accept", 32'(a), 32'd1);
    alu_valid = 1'b0;
  endtask

  initial begin
    bit a, l;
    int n;
    logic [XLEN-1:0] d7;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
    q_addr1 = 0; q_addr2 = 0;
    reset = 1'b1;
    @(negedge clk);
    cycle(a, l);
    cycle(a, l);
    reset = 1'b0;

    // Held ALU write to x3 through the INIT cycle.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEADBEEF;
    #1;
    chk("init_alu_ready", 32'(alu_ready), 32'd0);
    repeat (4) cycle(a, l);
    alu_valid = 1'b0;
    drain();
    chk("x3", rf_mem[3], 32'hDEADBEEF);

    // ALU and load together: ALU first, load afterwards.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'd1;
    ld_valid  = 1'b1; ld_rd  = 5'd6; ld_data  = 32'd2;
    cycle(a, l);
    chk("alu_first", 32'(a), 32'd1);
    alu_valid = 1'b0;
    n = 0;
    l = 1'b0;
    while (!l && n < 8) begin
      cycle(a, l);
      n++;
    end
    chk("ld_accept", 32'(l), 32'd1);
    ld_valid = 1'b0;
    drain();
    chk("x5", rf_mem[5], 32'd1);
    chk("x6", rf_mem[6], 32'd2);

    // Back-to-back pushes alternating x0 and x7.
    d7 = '0;
    for (int k = 0; k < 8; k++) begin
      alu_valid = 1'b1;
      alu_rd    = (k % 2 == 1) ? 5'd7 : 5'd0;
      alu_data  = $urandom;
      if (k % 2 == 1) d7 = alu_data;
      cycle(a, l);
      chk("stream_accept", 32'(a), 32'd1);
    end
    alu_valid = 1'b0;
    drain();
    chk("x0_never_written", 32'(rf_written[0]), 32'd0);
    chk("x7", rf_mem[7], d7);

    // Two pending writes to x9: the newer one must be bypassed.
    q_addr1 = 5'd9; q_addr2 = 5'd0;
    hold_alu(5'd9, 32'h10);
    hold_alu(5'd9, 32'h20);
    #1;
    chk("bp_hit1_newest",  32'(q_hit1), 32'(BP));
    chk("bp_data1_newest", q_data1, BP ? 32'h20 : 32'h0);
    chk("bp_hit2_x0",      32'(q_hit2), 32'd0);
    drain();
    chk("bp_hit1_after", 32'(q_hit1), 32'd0);
    chk("x9", rf_mem[9], 32'h20);

    // Reset in the middle of a stream of writes.
    for (int k = 0; k < 3; k++) begin
      alu_valid = 1'b1;
      alu_rd    = 5'(k + 10);
      alu_data  = $urandom;
      cycle(a, l);
    end
    reset = 1'b1;
    cycle(a, l);
    reset = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h5A5A;
    #1;
    chk("we_after_reset",   32'(rf_we),     32'd0);
    chk("busy_after_reset", 32'(busy),      32'd0);
    chk("init_ready_again", 32'(alu_ready), 32'd0);
    cycle(a, l);
    alu_valid = 1'b0;
    drain();

    // Randomized traffic with occasional resets.
    a = 1'b1;
    l = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!alu_valid || a) begin
        alu_valid = 1'($urandom_range(0, 1));
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!ld_valid || l) begin
        ld_valid = 1'($urandom_range(0, 1));
        ld_rd    = 5'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      q_addr1 = 5'($urandom_range(0, 9));
      q_addr2 = 5'($urandom_range(0, 9));
      reset   = ($urandom_range(0, 49) == 0);
      cycle(a, l);
    end
    reset = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    cycle(a, l);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
